aes_decrypt: RTL

AES_DECRYPT -- requirements
Module: aes_decrypt

---
 rtl/aes_decrypt.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/aes_decrypt.sv
// AES-256 iterative inverse cipher: 13-cycle key expansion into a round-key file, then one round per cycle.
// Optional macro AES_DECRYPT_KEYCACHE_EN skips key expansion when the next block reuses the last expanded key.
module aes_decrypt (
    input  logic         clk,
    input  logic         rst,
    input  logic         ready,
    input  logic [127:0] data_in,
    input  logic [255:0] key,
    output logic [127:0] data_out,
    output logic         valid
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] KEYEXP = 3'd1;
    localparam logic [2:0] INIT   = 3'd2;
    localparam logic [2:0] ROUND  = 3'd3;
    localparam logic [2:0] FINAL  = 3'd4;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] f_sbox(input logic [7:0] x);
        return SBOX[{8'd255 - x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] f_inv_sbox(input logic [7:0] x);
        return INV_SBOX[{8'd255 - x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] f_sub_word(input logic [31:0] w);
        return {f_sbox(w[31:24]), f_sbox(w[23:16]), f_sbox(w[15:8]), f_sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] f_xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] f_mul(input logic [7:0] b, input logic [3:0] m);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = f_xt(b);
        x4 = f_xt(x2);
        x8 = f_xt(x4);
        return x8 ^ (m[2] ? x4 : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[0] ? b : 8'h00);
    endfunction

    function automatic logic [31:0] f_inv_mix_col(input logic [31:0] c);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        {a0, a1, a2, a3} = c;
        return {f_mul(a0, 4'he) ^ f_mul(a1, 4'hb) ^ f_mul(a2, 4'hd) ^ f_mul(a3, 4'h9),
                f_mul(a0, 4'h9) ^ f_mul(a1, 4'he) ^ f_mul(a2, 4'hb) ^ f_mul(a3, 4'hd),
                f_mul(a0, 4'hd) ^ f_mul(a1, 4'h9) ^ f_mul(a2, 4'he) ^ f_mul(a3, 4'hb),
                f_mul(a0, 4'hb) ^ f_mul(a1, 4'hd) ^ f_mul(a2, 4'h9) ^ f_mul(a3, 4'he)};
    endfunction

    function automatic logic [127:0] f_inv_mix(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = f_inv_mix_col(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    // Byte (r + 4c) takes InvSubBytes of byte at row r, column (c - r) mod 4.
    function automatic logic [127:0] f_inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = f_inv_sbox(s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]);
            end
        end
        return o;
    endfunction

    logic [2:0]   r_fsm;
    logic [3:0]   r_kcnt;
    logic [3:0]   r_round;
    logic [127:0] r_ct;
    logic [127:0] r_state;
    logic [127:0] r_dout;
    logic         r_valid;
    logic [127:0] r_rk [0:14];

    logic [127:0] w_prev2;
    logic [127:0] w_prev1;
    logic [31:0]  w_last;
    logic [31:0]  w_temp;
    logic [31:0]  w_k0;
    logic [31:0]  w_k1;
    logic [31:0]  w_k2;
    logic [31:0]  w_k3;
    logic [127:0] w_round_key;
    logic [127:0] w_inv_sub;
    logic [127:0] w_add;
    logic [127:0] w_mix;

    // Round key (r_kcnt + 2) derives from the two previous round keys; even indices rotate and add Rcon.
    assign w_prev2 = r_rk[r_kcnt];
    assign w_prev1 = r_rk[r_kcnt + 4'd1];
    assign w_last  = w_prev1[31:0];
    assign w_temp  = r_kcnt[0] ? f_sub_word(w_last)
                               : (f_sub_word({w_last[23:0], w_last[31:24]}) ^ {8'h01 << r_kcnt[3:1], 24'h000000});
    assign w_k0    = w_prev2[127:96] ^ w_temp;
    assign w_k1    = w_prev2[95:64]  ^ w_k0;
    assign w_k2    = w_prev2[63:32]  ^ w_k1;
    assign w_k3    = w_prev2[31:0]   ^ w_k2;

    assign w_round_key = (r_fsm == FINAL) ? r_rk[0] : r_rk[r_round];
    assign w_inv_sub   = f_inv_shift_sub(r_state);
    assign w_add       = w_inv_sub ^ w_round_key;
    assign w_mix       = f_inv_mix(w_add);

`ifdef AES_DECRYPT_KEYCACHE_EN
    logic r_kvalid;
    logic w_khit;
    // rk0/rk1 hold the raw key of the last expansion, so they double as the cached key.
    assign w_khit = r_kvalid && (key == {r_rk[0], r_rk[1]});
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= IDLE;
            r_valid <= 1'b0;
            r_dout  <= '0;
            r_round <= '0;
            r_kcnt  <= '0;
`ifdef AES_DECRYPT_KEYCACHE_EN
            r_kvalid <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_fsm)
                IDLE: begin
                    if (ready) begin
                        r_ct    <= data_in;
                        r_rk[0] <= key[255:128];
                        r_rk[1] <= key[127:0];
                        r_kcnt  <= '0;
`ifdef AES_DECRYPT_KEYCACHE_EN
                        if (w_khit) begin
                            r_fsm <= INIT;
                        end else begin
                            r_fsm    <= KEYEXP;
                            r_kvalid <= 1'b0;
                        end
`else
                        r_fsm <= KEYEXP;
`endif
                    end
                end
                KEYEXP: begin
                    r_rk[r_kcnt + 4'd2] <= {w_k0, w_k1, w_k2, w_k3};
                    r_kcnt              <= r_kcnt + 4'd1;
                    if (r_kcnt == 4'd12) begin
                        r_fsm <= INIT;
`ifdef AES_DECRYPT_KEYCACHE_EN
                        r_kvalid <= 1'b1;
`endif
                    end
                end
                INIT: begin
                    r_state <= r_ct ^ r_rk[14];
                    r_round <= 4'd13;
                    r_fsm   <= ROUND;
                end
                ROUND: begin
                    r_state <= w_mix;
                    if (r_round != 4'd0) begin
                        r_round <= r_round - 4'd1;
                    end
                    if (r_round <= 4'd1) begin
                        r_fsm <= FINAL;
                    end
                end
                FINAL: begin
                    r_dout  <= w_add;
                    r_valid <= 1'b1;
                    r_fsm   <= IDLE;
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

    assign data_out = r_dout;
    assign valid    = r_valid;

endmodule
